// File: rtl/alu_req_sequencer.sv
// Request-side sequencer for the alu: merges split operand beats, issues one CE strobe,
// captures the registered ALU result after a fixed latency and returns it on a response handshake.
module alu_req_sequencer #(
    parameter int WIDTH     = 8,
    parameter int RES_WIDTH = 16,
    parameter int CMD_WIDTH = 4,
    parameter int LATENCY   = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 reqValid_i,
    output logic                 reqReady_o,
    input  logic [WIDTH-1:0]     reqOpa_i,
    input  logic [WIDTH-1:0]     reqOpb_i,
    input  logic                 reqCin_i,
    input  logic                 reqMode_i,
    input  logic [CMD_WIDTH-1:0] reqCmd_i,
    input  logic [1:0]           reqInpValid_i,
    output logic [WIDTH-1:0]     opa_o,
    output logic [WIDTH-1:0]     opb_o,
    output logic                 cin_o,
    output logic                 mode_o,
    output logic                 ce_o,
    output logic [CMD_WIDTH-1:0] cmd_o,
    output logic [1:0]           inpValid_o,
    input  logic [RES_WIDTH-1:0] aluRes_i,
    input  logic [5:0]           aluFlags_i,
    output logic                 rspValid_o,
    input  logic                 rspReady_i,
    output logic [RES_WIDTH-1:0] rspRes_o,
    output logic [5:0]           rspFlags_o,
    output logic                 rspTimeout_o
);

    localparam int CNT_MAX = (TIMEOUT > LATENCY) ? TIMEOUT : LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, WAIT, RESP} state_t;

    // Single-operand commands of the shared alu command encoding.
    function automatic logic [1:0] needOps(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
        logic [1:0] need;
        need = 2'b11;
        if (mode) begin
            if (cmd == CMD_WIDTH'(4) || cmd == CMD_WIDTH'(5))       need = 2'b01;
            else if (cmd == CMD_WIDTH'(6) || cmd == CMD_WIDTH'(7))  need = 2'b10;
        end else begin
            if (cmd == CMD_WIDTH'(6) || cmd == CMD_WIDTH'(8) || cmd == CMD_WIDTH'(9))
                need = 2'b01;
            else if (cmd == CMD_WIDTH'(7) || cmd == CMD_WIDTH'(10) || cmd == CMD_WIDTH'(11))
                need = 2'b10;
        end
        return need;
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             held_q, held_d;
    logic [WIDTH-1:0]       opaLat_q, opaLat_d, opbLat_q, opbLat_d;
    logic                   cinLat_q, cinLat_d, modeLat_q, modeLat_d;
    logic [CMD_WIDTH-1:0]   cmdLat_q, cmdLat_d;
    logic [WIDTH-1:0]       drvOpa_q, drvOpa_d, drvOpb_q, drvOpb_d;
    logic                   drvCin_q, drvCin_d, drvMode_q, drvMode_d, ce_q, ce_d;
    logic [CMD_WIDTH-1:0]   drvCmd_q, drvCmd_d;
    logic [1:0]             ivld_q, ivld_d;
    logic [RES_WIDTH-1:0]   rspRes_q, rspRes_d;
    logic [5:0]             rspFlags_q, rspFlags_d;
    logic                   rspTo_q, rspTo_d;
    logic                   acceptState, beat, goIssue;
    logic [1:0]             need;

    assign acceptState = (state_q == IDLE) || (state_q == COLLECT);
    assign beat        = reqValid_i && acceptState;
    assign need        = (state_q == IDLE) ? needOps(reqMode_i, reqCmd_i)
                                           : needOps(modeLat_q, cmdLat_q);

    // Ready is gated by reset so it reads 0 while reset is held even though the FSM sits in IDLE.
    assign reqReady_o   = acceptState && !rst_i;
    assign rspValid_o   = (state_q == RESP);
    assign opa_o        = drvOpa_q;
    assign opb_o        = drvOpb_q;
    assign cin_o        = drvCin_q;
    assign mode_o       = drvMode_q;
    assign cmd_o        = drvCmd_q;
    assign ce_o         = ce_q;
    assign inpValid_o   = ivld_q;
    assign rspRes_o     = rspRes_q;
    assign rspFlags_o   = rspFlags_q;
    assign rspTimeout_o = rspTo_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        held_d     = held_q;
        opaLat_d   = opaLat_q;
        opbLat_d   = opbLat_q;
        cinLat_d   = cinLat_q;
        modeLat_d  = modeLat_q;
        cmdLat_d   = cmdLat_q;
        drvOpa_d   = drvOpa_q;
        drvOpb_d   = drvOpb_q;
        drvCin_d   = drvCin_q;
        drvMode_d  = drvMode_q;
        drvCmd_d   = drvCmd_q;
        ce_d       = 1'b0;
        ivld_d     = 2'b00;
        rspRes_d   = rspRes_q;
        rspFlags_d = rspFlags_q;
        rspTo_d    = rspTo_q;
        goIssue    = 1'b0;

        case (state_q)
            IDLE: begin
                if (beat && reqInpValid_i != 2'b00) begin
                    cmdLat_d  = reqCmd_i;
                    modeLat_d = reqMode_i;
                    cinLat_d  = reqCin_i;
                    held_d    = reqInpValid_i;
                    opaLat_d  = reqInpValid_i[0] ? reqOpa_i : '0;
                    opbLat_d  = reqInpValid_i[1] ? reqOpb_i : '0;
                    if ((held_d & need) == need) begin
                        goIssue = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end
                end
            end
            COLLECT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (beat) begin
                    if (reqInpValid_i[0] && !held_q[0]) opaLat_d = reqOpa_i;
                    if (reqInpValid_i[1] && !held_q[1]) opbLat_d = reqOpb_i;
                    held_d = held_q | reqInpValid_i;
                end
                // A completing beat beats expiry in the same cycle.
                if ((held_d & need) == need) begin
                    goIssue = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = RESP;
                    rspRes_d   = '0;
                    rspFlags_d = '0;
                    rspTo_d    = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d    = RESP;
                    rspRes_d   = aluRes_i;
                    rspFlags_d = aluFlags_i;
                    rspTo_d    = 1'b0;
                end
            end
            RESP: begin
                if (rspReady_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (goIssue) begin
            state_d   = ISSUE;
            ce_d      = 1'b1;
            ivld_d    = held_d;
            drvOpa_d  = held_d[0] ? opaLat_d : '0;
            drvOpb_d  = held_d[1] ? opbLat_d : '0;
            drvCin_d  = cinLat_d;
            drvMode_d = modeLat_d;
            drvCmd_d  = cmdLat_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            held_q     <= '0;
            opaLat_q   <= '0;
            opbLat_q   <= '0;
            cinLat_q   <= 1'b0;
            modeLat_q  <= 1'b0;
            cmdLat_q   <= '0;
            drvOpa_q   <= '0;
            drvOpb_q   <= '0;
            drvCin_q   <= 1'b0;
            drvMode_q  <= 1'b0;
            drvCmd_q   <= '0;
            ce_q       <= 1'b0;
            ivld_q     <= '0;
            rspRes_q   <= '0;
            rspFlags_q <= '0;
            rspTo_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            held_q     <= held_d;
            opaLat_q   <= opaLat_d;
            opbLat_q   <= opbLat_d;
            cinLat_q   <= cinLat_d;
            modeLat_q  <= modeLat_d;
            cmdLat_q   <= cmdLat_d;
            drvOpa_q   <= drvOpa_d;
            drvOpb_q   <= drvOpb_d;
            drvCin_q   <= drvCin_d;
            drvMode_q  <= drvMode_d;
            drvCmd_q   <= drvCmd_d;
            ce_q       <= ce_d;
            ivld_q     <= ivld_d;
            rspRes_q   <= rspRes_d;
            rspFlags_q <= rspFlags_d;
            rspTo_q    <= rspTo_d;
        end
    end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed bench for alu_req_sequencer with a small two-stage registered alu stand-in.
module tb_alu_req_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid, reqReady, reqCin, reqMode, cin, mode, ce;
    logic [7:0]  reqOpa, reqOpb, opa, opb;
    logic [3:0]  reqCmd, cmd;
    logic [1:0]  reqInpValid, inpValid;
    logic [15:0] aluRes, rspRes;
    logic [5:0]  aluFlags, rspFlags;
    logic        rspValid, rspReady, rspTimeout;

    int testCount = 0;
    int failCount = 0;
    int ceCount   = 0;
    logic [1:0] lastIvld;
    logic [7:0] lastOpa, lastOpb;

    alu_req_sequencer dut (
        .clk_i(clk), .rst_i(rst),
        .reqValid_i(reqValid), .reqReady_o(reqReady),
        .reqOpa_i(reqOpa), .reqOpb_i(reqOpb), .reqCin_i(reqCin), .reqMode_i(reqMode),
        .reqCmd_i(reqCmd), .reqInpValid_i(reqInpValid),
        .opa_o(opa), .opb_o(opb), .cin_o(cin), .mode_o(mode), .ce_o(ce),
        .cmd_o(cmd), .inpValid_o(inpValid),
        .aluRes_i(aluRes), .aluFlags_i(aluFlags),
        .rspValid_o(rspValid), .rspReady_i(rspReady),
        .rspRes_o(rspRes), .rspFlags_o(rspFlags), .rspTimeout_o(rspTimeout)
    );

    always #5 clk = ~clk;

    // Minimal alu stand-in: ADD, SUB, INC_A, result visible two edges after CE.
    function automatic logic [21:0] aluModel(input logic m, input logic [3:0] c,
                                             input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = 9'd0;
        if (m && c == 4'd0) s = {1'b0, a} + {1'b0, b};
        else if (m && c == 4'd1) s = {1'b0, a - b};
        else if (m && c == 4'd4) s = {1'b0, a} + 9'd1;
        return {7'd0, s, 1'b0, s[8] & (c == 4'd0), 4'b0000};
    endfunction

    logic [21:0] stage1, stage2;
    always @(posedge clk) begin
        if (ce) stage1 <= aluModel(mode, cmd, opa, opb);
        stage2 <= stage1;
    end
    assign aluRes   = stage2[21:6];
    assign aluFlags = stage2[5:0];

    // Record every CE strobe and what the alu saw with it.
    always @(negedge clk) begin
        if (ce === 1'b1) begin
            ceCount  = ceCount + 1;
            lastIvld = inpValid;
            lastOpa  = opa;
            lastOpb  = opb;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one beat, hold it until it is taken, and return in the cycle after acceptance.
    task automatic applyStimulus(input logic [1:0] ivld, input logic m, input logic [3:0] c,
                                 input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        reqValid = 1'b1; reqInpValid = ivld; reqMode = m; reqCmd = c;
        reqOpa = a; reqOpb = b; reqCin = 1'b0;
        while (reqReady !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk); #1;
        reqValid = 1'b0; reqInpValid = 2'b00;
    endtask

    task automatic waitRsp(output int cyc);
        cyc = 1;
        while (rspValid !== 1'b1 && cyc < 200) begin
            @(negedge clk); #1; cyc++;
        end
        checkOutput("rspSeen", {31'd0, rspValid}, 32'd1);
    endtask

    task automatic finishRsp(input string tag);
        rspReady = 1'b1;
        @(negedge clk); #1;
        rspReady = 1'b0;
        checkOutput(tag, {30'd0, rspValid, reqReady}, 32'b01);
    endtask

    initial begin
        int cyc, ceBase;
        logic stable, readySeen, rspSeenEver;
        logic [15:0] holdRes;
        logic [5:0]  holdFlags;

        rst = 1'b1; reqValid = 1'b0; reqOpa = '0; reqOpb = '0; reqCin = 1'b0;
        reqMode = 1'b0; reqCmd = '0; reqInpValid = '0; rspReady = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetReady", {31'd0, reqReady}, 32'd0);
        checkOutput("resetOutputs", {ce, inpValid, opa, opb, rspValid, rspTimeout}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("readyAfterReset", {31'd0, reqReady}, 32'd1);

        // ADD FF+01 with both operands in one beat
        ceBase = ceCount;
        applyStimulus(2'b11, 1'b1, 4'd0, 8'hFF, 8'h01);
        waitRsp(cyc);
        checkOutput("addLatency", cyc, 32'd4);
        checkOutput("addCeCount", ceCount - ceBase, 32'd1);
        checkOutput("addIvld", {30'd0, lastIvld}, 32'b11);
        checkOutput("addRes", {16'd0, rspRes}, 32'h0100);
        checkOutput("addCout", {31'd0, rspFlags[4]}, 32'd1);
        checkOutput("addTimeout", {31'd0, rspTimeout}, 32'd0);
        finishRsp("addDone");

        // SUB split across two beats; second beat's command must be ignored
        ceBase = ceCount;
        applyStimulus(2'b01, 1'b1, 4'd1, 8'd5, 8'd0);
        repeat (2) @(negedge clk);
        #1;
        applyStimulus(2'b10, 1'b1, 4'd0, 8'd0, 8'd3);
        waitRsp(cyc);
        checkOutput("splitCeCount", ceCount - ceBase, 32'd1);
        checkOutput("splitIvld", {30'd0, lastIvld}, 32'b11);
        checkOutput("splitOps", {16'd0, lastOpa, lastOpb}, 32'h0503);
        checkOutput("splitRes", {16'd0, rspRes}, 32'd2);
        checkOutput("splitTimeout", {31'd0, rspTimeout}, 32'd0);
        finishRsp("splitDone");

        // ADD with only A supplied: expires after TIMEOUT collect cycles
        ceBase = ceCount;
        applyStimulus(2'b01, 1'b1, 4'd0, 8'h44, 8'h00);
        waitRsp(cyc);
        checkOutput("toLatency", cyc, 32'd17);
        checkOutput("toCeCount", ceCount - ceBase, 32'd0);
        checkOutput("toFlag", {31'd0, rspTimeout}, 32'd1);
        checkOutput("toResFlags", {10'd0, rspRes, rspFlags}, 32'd0);
        finishRsp("toDone");

        // Completing beat in the last collect cycle wins over expiry
        ceBase = ceCount;
        applyStimulus(2'b01, 1'b1, 4'd0, 8'h10, 8'h00);
        repeat (15) @(negedge clk);
        #1;
        applyStimulus(2'b10, 1'b1, 4'd0, 8'h00, 8'h20);
        waitRsp(cyc);
        checkOutput("raceTimeout", {31'd0, rspTimeout}, 32'd0);
        checkOutput("raceCeCount", ceCount - ceBase, 32'd1);
        checkOutput("raceRes", {16'd0, rspRes}, 32'h0030);
        finishRsp("raceDone");

        // Beat carrying no operands is dropped
        ceBase = ceCount;
        applyStimulus(2'b00, 1'b1, 4'd0, 8'h01, 8'h01);
        checkOutput("discardReady", {31'd0, reqReady}, 32'd1);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("discardNoOp", {ceCount - ceBase, 1'b0, rspValid}, 32'd0);

        // INC_A: no collect phase, single-operand issue, then back-pressure on the response
        applyStimulus(2'b01, 1'b1, 4'd4, 8'h7F, 8'h00);
        checkOutput("incCe", {29'd0, ce, inpValid}, 32'b101);
        waitRsp(cyc);
        checkOutput("incLatency", cyc, 32'd4);
        checkOutput("incRes", {16'd0, rspRes}, 32'h0080);
        holdRes = rspRes; holdFlags = rspFlags;
        stable = 1'b1; readySeen = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            if (rspValid !== 1'b1 || rspRes !== holdRes || rspFlags !== holdFlags || rspTimeout !== 1'b0)
                stable = 1'b0;
            if (reqReady !== 1'b0) readySeen = 1'b1;
        end
        checkOutput("rspStable", {31'd0, stable}, 32'd1);
        checkOutput("reqReadyInResp", {31'd0, readySeen}, 32'd0);
        finishRsp("incDone");

        // Reset during WAIT abandons the op
        applyStimulus(2'b11, 1'b1, 4'd0, 8'h11, 8'h22);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("rstDrive", {ce, inpValid, opa, opb, cmd, mode, cin, 1'b0}, 32'd0);
        checkOutput("rstRsp", {13'd0, rspValid, reqReady, rspRes, rspTimeout}, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("rstReadyAfter", {31'd0, reqReady}, 32'd1);
        rspSeenEver = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
            if (rspValid !== 1'b0) rspSeenEver = 1'b1;
        end
        checkOutput("rstNoRsp", {31'd0, rspSeenEver}, 32'd0);
        applyStimulus(2'b11, 1'b1, 4'd0, 8'd3, 8'd4);
        waitRsp(cyc);
        checkOutput("postRstLatency", cyc, 32'd4);
        checkOutput("postRstRes", {16'd0, rspRes}, 32'd7);
        finishRsp("postRstDone");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
